// File: rtl/image_filter_pkg.sv
// Shared types, kernel weights and clamp helper for the streaming 3x3 filter.
package image_filter_pkg;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_GAUSS = 2'd1,
      MODE_SHARP = 2'd2,
      MODE_SOBEL = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      RUN,
      FLUSH
   } state_e;

   localparam int GAUSS_C  = 4;
   localparam int GAUSS_E  = 2;
   localparam int GAUSS_K  = 1;
   localparam int GAUSS_SH = 4;
   localparam int SHARP_C  = 5;

   function automatic int clamp_px(input int v, input int maxv);
      if (v < 0)
         return 0;
      else if (v > maxv)
         return maxv;
      else
         return v;
   endfunction

endpackage

// File: rtl/image_filter_if.sv
// Pixel-in / pixel-out valid-ready bundle of the streaming filter.
interface image_filter_if
   import image_filter_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int CH    = 1
);
   logic                in_valid;
   logic                in_ready;
   logic [CH*PIX_W-1:0] in_pixel;
   logic                out_valid;
   logic                out_ready;
   logic [CH*PIX_W-1:0] out_pixel;
   logic                out_sof;
   logic                out_eol;

   modport slave (
      input  in_valid, in_pixel, out_ready,
      output in_ready, out_valid, out_pixel, out_sof, out_eol
   );

   modport master (
      output in_valid, in_pixel, out_ready,
      input  in_ready, out_valid, out_pixel, out_sof, out_eol
   );
endinterface

// File: rtl/filter_line_buffer.sv
// One image line of storage: combinational read of the old word, write on clk.
module filter_line_buffer
   import image_filter_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int DW    = 8
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            rdata
);
   logic [DW-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk)
      if (en) mem[addr] <= wdata;
endmodule

// File: rtl/image_filter_stream.sv
// Streaming 3x3 filter (pass/gauss/sharpen/sobel) over valid-ready streams.
// FILTER_SAT_CNT_EN adds the sat_count port counting clamped outputs.
module image_filter_stream
   import image_filter_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int CH    = 1,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    mode,
   image_filter_if.slave bus,
   output logic          busy
`ifdef FILTER_SAT_CNT_EN
   ,
   output logic [15:0]   sat_count
`endif
);
   localparam int DW   = CH * PIX_W;
   localparam int NPIX = IMG_W * IMG_H;
   localparam int CW   = $clog2(IMG_W);
   localparam int RW   = $clog2(IMG_H);
   localparam int AW   = $clog2(NPIX + 1);
   localparam int PMAX = (1 << PIX_W) - 1;

   state_e        state, state_nx;
   mode_e         mode_q;
   logic [AW-1:0] acc;
   logic [CW-1:0] icol, gcol;
   logic [RW-1:0] grow;
   logic          gen_done;
   logic          adv, take, step, emit, border;
   logic [DW-1:0] pix, rd0, rd1, res;
   logic          res_sat;
   logic [DW-1:0] win [3][3];
   logic [DW-1:0] nw  [3][3];
   int            nb  [3][3];
   int            v, gx, gy;

   assign adv          = !bus.out_valid | bus.out_ready;
   assign bus.in_ready = adv & (state != FLUSH);
   assign take         = bus.in_valid & bus.in_ready;
   assign step         = take | (adv & (state == FLUSH) & !gen_done);
   assign emit         = step & ((state == RUN) | (state == FLUSH));
   assign pix          = (state == FLUSH) ? '0 : bus.in_pixel;
   assign busy         = state != IDLE;
   assign border       = (grow == '0) | (grow == RW'(IMG_H-1)) |
                         (gcol == '0) | (gcol == CW'(IMG_W-1));

   filter_line_buffer #(.DEPTH(IMG_W), .DW(DW)) lb0 (
      .clk(clk), .en(step), .addr(icol), .wdata(pix), .rdata(rd0)
   );
   filter_line_buffer #(.DEPTH(IMG_W), .DW(DW)) lb1 (
      .clk(clk), .en(step), .addr(icol), .wdata(rd0), .rdata(rd1)
   );

   // The window as it will look after this step; the output is computed from it.
   always_comb begin
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 2; c++)
            nw[r][c] = win[r][c+1];
      nw[0][2] = rd1;
      nw[1][2] = rd0;
      nw[2][2] = pix;
   end

   always_ff @(posedge clk)
      if (step) win <= nw;

   always_comb begin
      res     = '0;
      res_sat = 1'b0;
      v       = 0;
      gx      = 0;
      gy      = 0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            nb[r][c] = 0;
      for (int ch = 0; ch < CH; ch++) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               nb[r][c] = int'(nw[r][c][ch*PIX_W +: PIX_W]);
         gx = (nb[0][2] + 2*nb[1][2] + nb[2][2]) -
              (nb[0][0] + 2*nb[1][0] + nb[2][0]);
         gy = (nb[2][0] + 2*nb[2][1] + nb[2][2]) -
              (nb[0][0] + 2*nb[0][1] + nb[0][2]);
         unique case (mode_q)
            MODE_PASS:  v = nb[1][1];
            MODE_GAUSS: v = (GAUSS_C*nb[1][1] +
                             GAUSS_E*(nb[0][1] + nb[2][1] + nb[1][0] + nb[1][2]) +
                             GAUSS_K*(nb[0][0] + nb[0][2] + nb[2][0] + nb[2][2]))
                            >>> GAUSS_SH;
            MODE_SHARP: v = SHARP_C*nb[1][1] -
                            nb[0][1] - nb[2][1] - nb[1][0] - nb[1][2];
            MODE_SOBEL: v = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
         endcase
         if (border) v = nb[1][1];
         if (v < 0 || v > PMAX) res_sat = 1'b1;
         res[ch*PIX_W +: PIX_W] = PIX_W'(clamp_px(v, PMAX));
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (take) state_nx = FILL;
         FILL:  if (take && acc == AW'(IMG_W)) state_nx = RUN;
         RUN:   if (take && acc == AW'(NPIX-1)) state_nx = FLUSH;
         FLUSH: if (gen_done && bus.out_valid && bus.out_ready) state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         mode_q        <= MODE_PASS;
         acc           <= '0;
         icol          <= '0;
         gcol          <= '0;
         grow          <= '0;
         gen_done      <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_pixel <= '0;
         bus.out_sof   <= 1'b0;
         bus.out_eol   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && take) begin
            mode_q <= mode_e'(mode);
            acc    <= AW'(1);
         end else if (take) begin
            acc <= acc + AW'(1);
         end
         if (step)
            icol <= (icol == CW'(IMG_W-1)) ? '0 : icol + CW'(1);
         if (emit) begin
            gcol <= (gcol == CW'(IMG_W-1)) ? '0 : gcol + CW'(1);
            if (gcol == CW'(IMG_W-1))
               grow <= (grow == RW'(IMG_H-1)) ? '0 : grow + RW'(1);
            if (gcol == CW'(IMG_W-1) && grow == RW'(IMG_H-1))
               gen_done <= 1'b1;
         end
         if (state == FLUSH && state_nx == IDLE) begin
            icol     <= '0;
            gen_done <= 1'b0;
         end
         if (adv) begin
            bus.out_valid <= emit;
            bus.out_pixel <= emit ? res : '0;
            bus.out_sof   <= emit & (gcol == '0) & (grow == '0);
            bus.out_eol   <= emit & (gcol == CW'(IMG_W-1));
         end
      end
   end

`ifdef FILTER_SAT_CNT_EN
   logic out_sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_sat   <= 1'b0;
         sat_count <= '0;
      end else begin
         if (adv) out_sat <= emit & res_sat;
         if (state == IDLE && take)
            sat_count <= '0;
         else if (bus.out_valid && bus.out_ready && out_sat && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
      end
   end
`else
   logic unused_sat;
   assign unused_sat = res_sat;
`endif
endmodule

// File: tb/tb_image_filter_stream.sv
// Randomised frame-level bench for image_filter_stream against a 3x3 reference model.
module tb_image_filter_stream;
   import image_filter_pkg::*;

   localparam int PIX_W = 8;
   localparam int CH    = 1;
   localparam int W     = 4;
   localparam int H     = 3;
   localparam int N     = W * H;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] mode  = 2'd0;
   logic       busy;
`ifdef FILTER_SAT_CNT_EN
   logic [15:0] sat_count;
`endif

   image_filter_if #(.PIX_W(PIX_W), .CH(CH)) bus ();

   image_filter_stream #(
      .PIX_W(PIX_W), .CH(CH), .IMG_W(W), .IMG_H(H)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mode(mode),
      .bus(bus),
      .busy(busy)
`ifdef FILTER_SAT_CNT_EN
      ,
      .sat_count(sat_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int img    [N];
   int got_px [N];
   int got_mk [N];

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int ref_raw(input int md, input int r, input int c);
      int p [3][3];
      int gx, gy;
      if (r == 0 || r == H-1 || c == 0 || c == W-1) return img[r*W + c];
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            p[i][j] = img[(r+i-1)*W + (c+j-1)];
      gx = p[0][2] + 2*p[1][2] + p[2][2] - p[0][0] - 2*p[1][0] - p[2][0];
      gy = p[2][0] + 2*p[2][1] + p[2][2] - p[0][0] - 2*p[0][1] - p[0][2];
      case (md)
         1: return (4*p[1][1] + 2*(p[0][1] + p[2][1] + p[1][0] + p[1][2]) +
                    p[0][0] + p[0][2] + p[2][0] + p[2][2]) / 16;
         2: return 5*p[1][1] - p[0][1] - p[2][1] - p[1][0] - p[1][2];
         3: return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
         default: return p[1][1];
      endcase
   endfunction

   function automatic int clamp8(input int x);
      return (x < 0) ? 0 : (x > 255) ? 255 : x;
   endfunction

   task automatic run_frame(input int md, input bit tgl, input bit rnd, input int abort_at);
      int  n_acc = 0, n_out = 0, cyc = 0;
      int  acc_cyc = -100, first_cyc = -1;
      int  flush_bad = 0, early = 0, exp_sat = 0, raw;
      bit  done = 0;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         if (abort_at >= 0 && n_acc == abort_at) begin
            rst_n = 1'b0;
            bus.in_valid = 1'b0;
            #1;
            check("abort_out_valid", int'(bus.out_valid), 0);
            check("abort_busy", int'(busy), 0);
            check("abort_in_ready", int'(bus.in_ready), 1);
            check("abort_out_pixel", int'(bus.out_pixel), 0);
            check("abort_marks", int'({bus.out_sof, bus.out_eol}), 0);
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         bus.out_ready = tgl ? (cyc % 2 == 0) : 1'b1;
         bus.in_valid  = (n_acc < N) && (!rnd || $urandom_range(0, 2) != 0);
         if (n_acc < N) bus.in_pixel = 8'(img[n_acc]);
         else           bus.in_pixel = 8'($urandom);
         if (n_acc > 0) mode = 2'($urandom);
         else           mode = 2'(md);
         #1;
         if (n_acc == N && busy && bus.in_ready) flush_bad++;
         if (bus.out_valid && n_acc < W + 2) early++;
         if (bus.out_valid && first_cyc < 0) first_cyc = cyc;
         if (bus.in_valid && bus.in_ready) begin
            if (n_acc == W + 1) acc_cyc = cyc;
            n_acc++;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (n_out < N) begin
               got_px[n_out] = int'(bus.out_pixel);
               got_mk[n_out] = int'({bus.out_sof, bus.out_eol});
            end
            n_out++;
         end
         if (n_out >= N && !busy) done = 1;
         cyc++;
      end
      check("frame_done", int'(done), 1);
      check("out_count", n_out, N);
      check("flush_in_ready", flush_bad, 0);
      check("early_valid", early, 0);
      check("first_latency", first_cyc - acc_cyc, 1);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            raw = ref_raw(md, r, c);
            if (raw < 0 || raw > 255) exp_sat++;
            check($sformatf("px m%0d r%0d c%0d", md, r, c),
                  got_px[r*W + c], clamp8(raw));
            check($sformatf("marks r%0d c%0d", r, c), got_mk[r*W + c],
                  ((r == 0 && c == 0) ? 2 : 0) + ((c == W-1) ? 1 : 0));
         end
`ifdef FILTER_SAT_CNT_EN
      check("sat_count", int'(sat_count), exp_sat);
`else
      if (exp_sat < 0) $display("unexpected negative saturation count");
`endif
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_pixel  = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_in_ready", int'(bus.in_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_out_pixel", int'(bus.out_pixel), 0);
      check("rst_marks", int'({bus.out_sof, bus.out_eol}), 0);
      rst_n = 1'b1;

      for (int i = 0; i < N; i++) img[i] = i;
      run_frame(0, 0, 0, -1);

      for (int i = 0; i < N; i++) img[i] = 100;
      run_frame(1, 0, 0, -1);

      for (int i = 0; i < N; i++) img[i] = 0;
      img[1*W + 1] = 200;
      run_frame(1, 0, 0, -1);
      check("gauss_r1c1", got_px[1*W + 1], 50);
      check("gauss_r1c2", got_px[1*W + 2], 25);

      for (int i = 0; i < N; i++) img[i] = 10;
      img[1*W + 1] = 60;
      run_frame(2, 0, 0, -1);
      check("sharp_hi_clamp", got_px[1*W + 1], 255);

      for (int i = 0; i < N; i++) img[i] = 50;
      img[1*W + 1] = 0;
      run_frame(2, 0, 0, -1);
      check("sharp_lo_clamp", got_px[1*W + 1], 0);

      for (int i = 0; i < N; i++) img[i] = (i % W == 0) ? 0 : 255;
      run_frame(3, 0, 0, -1);
      check("sobel_edge", got_px[1*W + 1], 255);

      for (int i = 0; i < N; i++) img[i] = 77;
      run_frame(3, 0, 0, -1);
      check("sobel_flat_c1", got_px[1*W + 1], 0);
      check("sobel_flat_c2", got_px[1*W + 2], 0);

      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
         run_frame(k % 4, 1'b1, 1'b1, -1);
      end

      for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
      run_frame(2, 1'b0, 1'b0, 7);
      for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
      run_frame(2, 1'b0, 1'b1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
